// File: rtl/mem_io_responder.sv
// Byte-bus responder: 128KB RAM, UART rx/tx FIFOs, cycle counter and stop port.
// Define MEM_IO_ERRCNT_EN to add an unmapped-access error counter at 0x30008.
module mem_io_responder #(
   parameter int RAM_ADDR_W  = 17,
   parameter int TX_DEPTH    = 8,
   parameter int RX_DEPTH    = 8,
   parameter int FULL_MARGIN = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] cpu_a,
   input  logic        cpu_wr,
   input  logic [7:0]  cpu_dout,
   output logic [7:0]  cpu_din,
   output logic        io_buffer_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        program_stop,
   output logic        halted
);

   localparam int TXP = $clog2(TX_DEPTH);
   localparam int RXP = $clog2(RX_DEPTH);
   localparam logic [TXP:0] TX_N  = TX_DEPTH[TXP:0];
   localparam logic [TXP:0] TX_HI = TX_N - FULL_MARGIN[TXP:0];
   localparam logic [RXP:0] RX_N  = RX_DEPTH[RXP:0];

   logic [3:0] io_sel;
   logic       is_ram, is_io, uart_sel, cnt_sel;
   logic       uart_rd, cnt_rd, data_wr, stop_wr;
   logic       unused_a;

   assign io_sel   = cpu_a[3:0];
   assign is_ram   = ~cpu_a[17];
   assign is_io    = cpu_a[17] & cpu_a[16];
   assign uart_sel = is_io && io_sel == 4'h0;
   assign cnt_sel  = is_io && io_sel[3:2] == 2'b01;
   assign uart_rd  = uart_sel && !cpu_wr;
   assign cnt_rd   = cnt_sel && !cpu_wr;
   assign data_wr  = uart_sel && cpu_wr && cpu_dout != 8'h00;
   assign stop_wr  = cnt_sel && cpu_wr && io_sel[1:0] == 2'b00;
   assign unused_a = ^cpu_a[31:18];

   // RAM: registered read, no reset on contents
   logic [7:0] ram [0:(1<<RAM_ADDR_W)-1];
   logic [7:0] ram_q;

   always_ff @(posedge clk_in) begin
      if (is_ram && cpu_wr)
         ram[cpu_a[RAM_ADDR_W-1:0]] <= cpu_dout;
      if (is_ram && !cpu_wr)
         ram_q <= ram[cpu_a[RAM_ADDR_W-1:0]];
   end

   // tx FIFO; a stop byte has priority over a same-cycle data write
   logic [7:0]     tx_mem [TX_DEPTH];
   logic [TXP-1:0] tx_wp, tx_rp;
   logic [TXP:0]   tx_cnt, tx_cnt_nxt;
   logic           stop_pend, stop_req;
   logic           tx_full, tx_push, tx_pop;
   logic [7:0]     tx_push_d;

   assign tx_full   = tx_cnt == TX_N;
   assign stop_req  = stop_wr | stop_pend;
   assign tx_push_d = stop_req ? 8'h00 : cpu_dout;
   assign tx_push   = (stop_req | data_wr) & ~tx_full;
   assign tx_valid  = tx_cnt != '0;
   assign tx_pop    = tx_valid & tx_ready;
   assign tx_data   = tx_mem[tx_rp];

   always_comb begin
      tx_cnt_nxt = tx_cnt;
      if (tx_push && !tx_pop)
         tx_cnt_nxt = tx_cnt + 1'b1;
      else if (!tx_push && tx_pop)
         tx_cnt_nxt = tx_cnt - 1'b1;
   end

   always_ff @(posedge clk_in) begin
      if (tx_push)
         tx_mem[tx_wp] <= tx_push_d;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         tx_wp          <= '0;
         tx_rp          <= '0;
         tx_cnt         <= '0;
         stop_pend      <= 1'b0;
         io_buffer_full <= 1'b0;
      end else begin
         if (tx_push)
            tx_wp <= tx_wp + 1'b1;
         if (tx_pop)
            tx_rp <= tx_rp + 1'b1;
         tx_cnt         <= tx_cnt_nxt;
         stop_pend      <= stop_req & tx_full;
         io_buffer_full <= tx_cnt_nxt >= TX_HI;
      end
   end

   // rx FIFO; a pop is only granted on a non-empty FIFO
   logic [7:0]     rx_mem [RX_DEPTH];
   logic [RXP-1:0] rx_wp, rx_rp;
   logic [RXP:0]   rx_cnt;
   logic           rx_push, rx_pop;

   assign rx_push = rx_valid & (rx_cnt != RX_N);
   assign rx_pop  = uart_rd & (rx_cnt != '0);

   always_ff @(posedge clk_in) begin
      if (rx_push)
         rx_mem[rx_wp] <= rx_data;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         rx_wp  <= '0;
         rx_rp  <= '0;
         rx_cnt <= '0;
      end else begin
         if (rx_push)
            rx_wp <= rx_wp + 1'b1;
         if (rx_pop)
            rx_rp <= rx_rp + 1'b1;
         if (rx_push && !rx_pop)
            rx_cnt <= rx_cnt + 1'b1;
         else if (!rx_push && rx_pop)
            rx_cnt <= rx_cnt - 1'b1;
      end
   end

   // Cycle counter with a snapshot taken on the low-byte read
   logic [31:0] cycle_cnt, snap;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         cycle_cnt    <= '0;
         snap         <= '0;
         halted       <= 1'b0;
         program_stop <= 1'b0;
      end else begin
         if (!halted)
            cycle_cnt <= cycle_cnt + 1'b1;
         if (cnt_rd && io_sel[1:0] == 2'b00)
            snap <= cycle_cnt;
         program_stop <= stop_wr;
         if (stop_wr)
            halted <= 1'b1;
      end
   end

`ifdef MEM_IO_ERRCNT_EN
   logic [15:0] err_cnt;
   logic        is_unm, err_rd;

   assign is_unm = cpu_a[17] & ~cpu_a[16];
   assign err_rd = is_io && !cpu_wr && io_sel[3:1] == 3'b100;

   always_ff @(posedge clk_in) begin
      if (rst_in)
         err_cnt <= '0;
      else if (is_io && cpu_wr && io_sel == 4'h8)
         err_cnt <= '0;
      else if (is_unm && err_cnt != 16'hFFFF)
         err_cnt <= err_cnt + 1'b1;
   end
`else
   logic [15:0] err_cnt;
   logic        err_rd;

   assign err_cnt = '0;
   assign err_rd  = 1'b0;
`endif

   logic [7:0] io_d;
   logic [7:0] io_q;
   logic       rd_ram_q;

   always_comb begin
      io_d = 8'h00;
      unique case (1'b1)
         uart_rd: begin
            if (rx_cnt != '0)
               io_d = rx_mem[rx_rp];
         end
         cnt_rd: begin
            case (io_sel[1:0])
               2'd0: io_d = cycle_cnt[7:0];
               2'd1: io_d = snap[15:8];
               2'd2: io_d = snap[23:16];
               2'd3: io_d = snap[31:24];
            endcase
         end
         err_rd: io_d = io_sel[0] ? err_cnt[15:8] : err_cnt[7:0];
         default: io_d = 8'h00;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         rd_ram_q <= 1'b0;
         io_q     <= 8'h00;
      end else begin
         rd_ram_q <= is_ram & ~cpu_wr;
         io_q     <= io_d;
      end
   end

   assign cpu_din = rd_ram_q ? ram_q : io_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: bus reads, tx stream, rx pops,
// counter snapshot and stop port.
module tb_mem_io_responder;

   localparam logic [31:0] IDLE = 32'h0003000F;

   logic        clk = 1'b0;
   logic        rst_in;
   logic [31:0] cpu_a;
   logic        cpu_wr;
   logic [7:0]  cpu_dout;
   logic [7:0]  cpu_din;
   logic        io_buffer_full;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        program_stop;
   logic        halted;

   int          n_chk = 0;
   int          n_pass = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  tx_exp[$];
   logic [7:0]  tx_got[$];
   logic [31:0] mcnt = '0;
   logic [31:0] msnap = '0;
   logic        mhalt = 1'b0;

   always #5 clk = ~clk;

   mem_io_responder dut (
      .clk_in(clk),
      .rst_in(rst_in),
      .cpu_a(cpu_a),
      .cpu_wr(cpu_wr),
      .cpu_dout(cpu_dout),
      .cpu_din(cpu_din),
      .io_buffer_full(io_buffer_full),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .program_stop(program_stop),
      .halted(halted)
   );

   // One bus cycle; records accepted tx bytes and tracks the counter model
   task automatic cyc(input logic [31:0] a, input logic w,
                      input logic [7:0] d);
      @(negedge clk);
      cpu_a    = a;
      cpu_wr   = w;
      cpu_dout = d;
      #4;
      if (tx_valid && tx_ready)
         tx_got.push_back(tx_data);
      @(posedge clk);
      #1;
      if (rst_in) begin
         mcnt  = '0;
         mhalt = 1'b0;
      end else begin
         if (!mhalt)
            mcnt = mcnt + 1;
         if (w && a == 32'h00030004)
            mhalt = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst_in   = 1'b1;
      tx_ready = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      cyc(IDLE, 1'b0, 8'h00);
      cyc(IDLE, 1'b0, 8'h00);
      n_chk++;
      if (cpu_din !== 8'h00)
         $display("FAIL rst_din: got %h want 00", cpu_din);
      else n_pass++;
      n_chk++;
      if (io_buffer_full !== 1'b0)
         $display("FAIL rst_full: got %b want 0", io_buffer_full);
      else n_pass++;
      n_chk++;
      if (tx_valid !== 1'b0)
         $display("FAIL rst_txv: got %b want 0", tx_valid);
      else n_pass++;
      n_chk++;
      if (program_stop !== 1'b0)
         $display("FAIL rst_stop: got %b want 0", program_stop);
      else n_pass++;
      n_chk++;
      if (halted !== 1'b0)
         $display("FAIL rst_halt: got %b want 0", halted);
      else n_pass++;
      rst_in = 1'b0;
   endtask

   task automatic test_ram();
      logic [31:0] ra[6];
      logic [7:0]  rv[6];
      logic [7:0]  e;
      cyc(32'h00010, 1'b1, 8'hA5);
      exp_q.push_back(8'hA5);
      cyc(32'h00010, 1'b0, 8'h00);
      e = exp_q.pop_front();
      n_chk++;
      if (cpu_din !== e)
         $display("FAIL ram_raw: got %h want %h", cpu_din, e);
      else n_pass++;
      cyc(32'h1FFFF, 1'b1, 8'h5A);
      cyc(32'h0FFFF, 1'b1, 8'hC3);
      cyc(32'h20010, 1'b1, 8'h77);
      cyc(32'h30001, 1'b1, 8'h99);
      ra = '{32'h10, 32'h1FFFF, 32'h0FFFF, 32'h20010, 32'h30001, 32'h3000A};
      rv = '{8'hA5, 8'h5A, 8'hC3, 8'h00, 8'h00, 8'h00};
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back(rv[i]);
         cyc(ra[i], 1'b0, 8'h00);
         e = exp_q.pop_front();
         n_chk++;
         if (cpu_din !== e)
            $display("FAIL rd_%h: got %h want %h", ra[i], cpu_din, e);
         else n_pass++;
      end
`ifndef MEM_IO_ERRCNT_EN
      cyc(32'h30008, 1'b0, 8'h00);
      n_chk++;
      if (cpu_din !== 8'h00)
         $display("FAIL rd_errcnt: got %h want 00", cpu_din);
      else n_pass++;
`endif
   endtask

   task automatic test_tx_filter();
      logic [7:0] e, g;
      tx_ready = 1'b1;
      tx_got.delete();
      tx_exp.delete();
      cyc(32'h30000, 1'b1, 8'h41);
      tx_exp.push_back(8'h41);
      cyc(32'h30000, 1'b1, 8'h00);
      cyc(32'h30000, 1'b1, 8'h42);
      tx_exp.push_back(8'h42);
      repeat (4) cyc(IDLE, 1'b0, 8'h00);
      n_chk++;
      if (tx_got.size() != tx_exp.size())
         $display("FAIL filt_len: got %0d want %0d", tx_got.size(), tx_exp.size());
      else n_pass++;
      while (tx_exp.size() > 0) begin
         e = tx_exp.pop_front();
         g = (tx_got.size() > 0) ? tx_got.pop_front() : 8'hxx;
         n_chk++;
         if (g !== e)
            $display("FAIL filt_byte: got %h want %h", g, e);
         else n_pass++;
      end
      n_chk++;
      if (tx_valid !== 1'b0)
         $display("FAIL filt_txv: got %b want 0", tx_valid);
      else n_pass++;
   endtask

   task automatic test_tx_full();
      logic [7:0] e, g;
      int         mc;
      logic       ef;
      mc       = 0;
      tx_ready = 1'b0;
      tx_got.delete();
      tx_exp.delete();
      for (int i = 0; i < 9; i++) begin
         cyc(32'h30000, 1'b1, 8'(8'h11 + i));
         if (mc < 8) begin
            tx_exp.push_back(8'(8'h11 + i));
            mc++;
         end
         ef = (mc >= 6);
         n_chk++;
         if (io_buffer_full !== ef)
            $display("FAIL full_%0d: got %b want %b", i, io_buffer_full, ef);
         else n_pass++;
      end
      tx_ready = 1'b1;
      repeat (12) cyc(IDLE, 1'b0, 8'h00);
      n_chk++;
      if (tx_got.size() != tx_exp.size())
         $display("FAIL drain_len: got %0d want %0d", tx_got.size(), tx_exp.size());
      else n_pass++;
      while (tx_exp.size() > 0) begin
         e = tx_exp.pop_front();
         g = (tx_got.size() > 0) ? tx_got.pop_front() : 8'hxx;
         n_chk++;
         if (g !== e)
            $display("FAIL drain_byte: got %h want %h", g, e);
         else n_pass++;
      end
      n_chk++;
      if (io_buffer_full !== 1'b0 || tx_valid !== 1'b0)
         $display("FAIL drain_end: got full=%b txv=%b want 0 0",
                  io_buffer_full, tx_valid);
      else n_pass++;
   endtask

   task automatic test_rx();
      logic [7:0] e;
      rx_valid = 1'b1;
      rx_data  = 8'h31;
      cyc(IDLE, 1'b0, 8'h00);
      rx_data  = 8'h32;
      cyc(IDLE, 1'b0, 8'h00);
      rx_valid = 1'b0;
      exp_q.push_back(8'h31);
      exp_q.push_back(8'h32);
      exp_q.push_back(8'h00);
      repeat (3) begin
         cyc(32'h30000, 1'b0, 8'h00);
         e = exp_q.pop_front();
         n_chk++;
         if (cpu_din !== e)
            $display("FAIL rx_rd: got %h want %h", cpu_din, e);
         else n_pass++;
      end
      rx_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         rx_data = 8'(8'h50 + i);
         cyc(IDLE, 1'b0, 8'h00);
         if (i < 8)
            exp_q.push_back(8'(8'h50 + i));
      end
      rx_valid = 1'b0;
      exp_q.push_back(8'h00);
      repeat (9) begin
         cyc(32'h30000, 1'b0, 8'h00);
         e = exp_q.pop_front();
         n_chk++;
         if (cpu_din !== e)
            $display("FAIL rx_full_rd: got %h want %h", cpu_din, e);
         else n_pass++;
      end
      rx_valid = 1'b1;
      rx_data  = 8'h66;
      exp_q.push_back(8'h00);
      cyc(32'h30000, 1'b0, 8'h00);
      rx_valid = 1'b0;
      exp_q.push_back(8'h66);
      exp_q.push_back(8'h00);
      repeat (3) begin
         e = exp_q.pop_front();
         n_chk++;
         if (cpu_din !== e)
            $display("FAIL rx_pushpop: got %h want %h", cpu_din, e);
         else n_pass++;
         cyc(32'h30000, 1'b0, 8'h00);
      end
      cyc(IDLE, 1'b0, 8'h00);
   endtask

   task automatic test_reset_mid();
      logic [7:0] e;
      tx_ready = 1'b0;
      tx_got.delete();
      cyc(32'h30000, 1'b1, 8'h33);
      rx_valid = 1'b1;
      rx_data  = 8'h44;
      cyc(IDLE, 1'b0, 8'h00);
      rx_valid = 1'b0;
      rst_in   = 1'b1;
      cyc(IDLE, 1'b0, 8'h00);
      rst_in   = 1'b0;
      n_chk++;
      if (tx_valid !== 1'b0)
         $display("FAIL mid_txv: got %b want 0", tx_valid);
      else n_pass++;
      tx_ready = 1'b1;
      repeat (3) cyc(IDLE, 1'b0, 8'h00);
      n_chk++;
      if (tx_got.size() != 0)
         $display("FAIL mid_tx: got %0d bytes want 0", tx_got.size());
      else n_pass++;
      exp_q.push_back(8'h00);
      cyc(32'h30000, 1'b0, 8'h00);
      e = exp_q.pop_front();
      n_chk++;
      if (cpu_din !== e)
         $display("FAIL mid_rx: got %h want %h", cpu_din, e);
      else n_pass++;
      exp_q.push_back(8'hA5);
      cyc(32'h00010, 1'b0, 8'h00);
      e = exp_q.pop_front();
      n_chk++;
      if (cpu_din !== e)
         $display("FAIL mid_ram: got %h want %h", cpu_din, e);
      else n_pass++;
   endtask

   task automatic test_counter();
      logic [7:0] e;
      int         guard;
      rst_in = 1'b1;
      cyc(IDLE, 1'b0, 8'h00);
      rst_in = 1'b0;
      repeat (100) cyc(IDLE, 1'b0, 8'h00);
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 1) begin
            guard = 0;
            while (mcnt != 32'h1FF && guard < 1000) begin
               cyc(IDLE, 1'b0, 8'h00);
               guard++;
            end
         end
         for (int k = 0; k < 4; k++) begin
            if (k == 0) begin
               e     = mcnt[7:0];
               msnap = mcnt;
            end else begin
               e = msnap[8*k +: 8];
            end
            exp_q.push_back(e);
            cyc(32'h30004 + k, 1'b0, 8'h00);
            e = exp_q.pop_front();
            n_chk++;
            if (cpu_din !== e)
               $display("FAIL cnt%0d_b%0d: got %h want %h", pass, k, cpu_din, e);
            else n_pass++;
         end
      end
   endtask

   task automatic test_stop();
      logic [7:0] e, g;
      tx_ready = 1'b1;
      tx_got.delete();
      tx_exp.delete();
      cyc(32'h30004, 1'b1, 8'h77);
      tx_exp.push_back(8'h00);
      n_chk++;
      if (program_stop !== 1'b1 || halted !== 1'b1)
         $display("FAIL stop_set: got ps=%b h=%b want 1 1", program_stop, halted);
      else n_pass++;
      cyc(IDLE, 1'b0, 8'h00);
      n_chk++;
      if (program_stop !== 1'b0 || halted !== 1'b1)
         $display("FAIL stop_pulse: got ps=%b h=%b want 0 1", program_stop, halted);
      else n_pass++;
      repeat (10) cyc(IDLE, 1'b0, 8'h00);
      for (int k = 0; k < 4; k++) begin
         e = mcnt[8*k +: 8];
         exp_q.push_back(e);
         cyc(32'h30004 + k, 1'b0, 8'h00);
         e = exp_q.pop_front();
         n_chk++;
         if (cpu_din !== e)
            $display("FAIL frozen_b%0d: got %h want %h", k, cpu_din, e);
         else n_pass++;
      end
      tx_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cyc(32'h30000, 1'b1, 8'(8'h21 + i));
         tx_exp.push_back(8'(8'h21 + i));
      end
      cyc(32'h30004, 1'b1, 8'h00);
      tx_exp.push_back(8'h00);
      n_chk++;
      if (program_stop !== 1'b1)
         $display("FAIL stop_full_ps: got %b want 1", program_stop);
      else n_pass++;
      repeat (3) cyc(IDLE, 1'b0, 8'h00);
      tx_ready = 1'b1;
      repeat (14) cyc(IDLE, 1'b0, 8'h00);
      n_chk++;
      if (tx_got.size() != tx_exp.size())
         $display("FAIL stop_len: got %0d want %0d", tx_got.size(), tx_exp.size());
      else n_pass++;
      while (tx_exp.size() > 0) begin
         e = tx_exp.pop_front();
         g = (tx_got.size() > 0) ? tx_got.pop_front() : 8'hxx;
         n_chk++;
         if (g !== e)
            $display("FAIL stop_byte: got %h want %h", g, e);
         else n_pass++;
      end
   endtask

   initial begin
      rst_in   = 1'b1;
      cpu_a    = IDLE;
      cpu_wr   = 1'b0;
      cpu_dout = 8'h00;
      tx_ready = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      test_reset();
      test_ram();
      test_tx_filter();
      test_tx_full();
      test_rx();
      test_reset_mid();
      test_counter();
      test_stop();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
